// File: rtl/riscv_mem_sequencer.sv
// Multicycle sequencer that time-shares one single-port memory between instruction
// fetch and data access for a single-cycle RISC-V core, committing via core_step.
module riscv_mem_sequencer #(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned TIMEOUT = 16,
   parameter logic [31:0] NOP     = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] core_pc,
   output logic [31:0]     core_instr,
   input  logic            core_memread,
   input  logic            core_memwrite,
   input  logic [XLEN-1:0] core_addr,
   input  logic [XLEN-1:0] core_wdata,
   output logic [XLEN-1:0] core_rdata,
   output logic            core_step,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ack,
   input  logic            halt_req,
   output logic            halted,
   output logic            fault,
   output logic [XLEN-1:0] instret
);

   localparam int unsigned WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      FETCH_ISSUE = 3'd0,
      FETCH_WAIT  = 3'd1,
      EXEC        = 3'd2,
      MEM_WAIT    = 3'd3,
      COMMIT      = 3'd4,
      HALT        = 3'd5,
      FAULT       = 3'd6
   } state_t;

   state_t            state, state_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic [31:0]       core_instr_nxt;
   logic [XLEN-1:0]   core_rdata_nxt;
   logic              core_step_nxt;
   logic              mem_req_nxt;
   logic              mem_we_nxt;
   logic [XLEN-1:0]   mem_addr_nxt;
   logic [XLEN-1:0]   mem_wdata_nxt;
   logic              halted_nxt;
   logic              fault_nxt;
   logic [XLEN-1:0]   instret_nxt;

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= FETCH_ISSUE;
         wait_cnt   <= '0;
         core_instr <= NOP;
         core_rdata <= '0;
         core_step  <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         halted     <= 1'b0;
         fault      <= 1'b0;
         instret    <= '0;
      end else begin
         state      <= state_nxt;
         wait_cnt   <= wait_cnt_nxt;
         core_instr <= core_instr_nxt;
         core_rdata <= core_rdata_nxt;
         core_step  <= core_step_nxt;
         mem_req    <= mem_req_nxt;
         mem_we     <= mem_we_nxt;
         mem_addr   <= mem_addr_nxt;
         mem_wdata  <= mem_wdata_nxt;
         halted     <= halted_nxt;
         fault      <= fault_nxt;
         instret    <= instret_nxt;
      end
   end

   // Next-state and next-output logic; core_step/instret are set on entry to COMMIT
   always_comb begin
      state_nxt      = state;
      wait_cnt_nxt   = wait_cnt;
      core_instr_nxt = core_instr;
      core_rdata_nxt = core_rdata;
      core_step_nxt  = 1'b0;
      mem_req_nxt    = mem_req;
      mem_we_nxt     = mem_we;
      mem_addr_nxt   = mem_addr;
      mem_wdata_nxt  = mem_wdata;
      halted_nxt     = halted;
      fault_nxt      = fault;
      instret_nxt    = instret;

      case (state)
         FETCH_ISSUE: begin
            if (core_pc[1:0] != 2'b00) begin
               fault_nxt = 1'b1;
               state_nxt = FAULT;
            end else begin
               mem_req_nxt  = 1'b1;
               mem_we_nxt   = 1'b0;
               mem_addr_nxt = core_pc;
               wait_cnt_nxt = '0;
               state_nxt    = FETCH_WAIT;
            end
         end

         FETCH_WAIT: begin
            if (mem_ack) begin
               core_instr_nxt = mem_rdata[31:0];
               mem_req_nxt    = 1'b0;
               state_nxt      = EXEC;
            end else if (wait_cnt == WAIT_LAST) begin
               mem_req_nxt = 1'b0;
               fault_nxt   = 1'b1;
               state_nxt   = FAULT;
            end else begin
               wait_cnt_nxt = wait_cnt + WAIT_W'(1);
            end
         end

         EXEC: begin
            if (core_memread && core_memwrite) begin
               fault_nxt = 1'b1;
               state_nxt = FAULT;
            end else if (core_memread) begin
               mem_req_nxt  = 1'b1;
               mem_we_nxt   = 1'b0;
               mem_addr_nxt = core_addr;
               wait_cnt_nxt = '0;
               state_nxt    = MEM_WAIT;
            end else if (core_memwrite) begin
               mem_req_nxt   = 1'b1;
               mem_we_nxt    = 1'b1;
               mem_addr_nxt  = core_addr;
               mem_wdata_nxt = core_wdata;
               wait_cnt_nxt  = '0;
               state_nxt     = MEM_WAIT;
            end else begin
               core_step_nxt = 1'b1;
               instret_nxt   = instret + XLEN'(1);
               state_nxt     = COMMIT;
            end
         end

         MEM_WAIT: begin
            // mem_we still identifies the access kind since it is held during the request
            if (mem_ack) begin
               if (!mem_we) begin
                  core_rdata_nxt = mem_rdata;
               end
               mem_req_nxt   = 1'b0;
               core_step_nxt = 1'b1;
               instret_nxt   = instret + XLEN'(1);
               state_nxt     = COMMIT;
            end else if (wait_cnt == WAIT_LAST) begin
               mem_req_nxt = 1'b0;
               fault_nxt   = 1'b1;
               state_nxt   = FAULT;
            end else begin
               wait_cnt_nxt = wait_cnt + WAIT_W'(1);
            end
         end

         COMMIT: begin
            if (halt_req) begin
               halted_nxt = 1'b1;
               state_nxt  = HALT;
            end else begin
               state_nxt = FETCH_ISSUE;
            end
         end

         HALT: begin
            if (!halt_req) begin
               halted_nxt = 1'b0;
               state_nxt  = FETCH_ISSUE;
            end
         end

         FAULT: begin
            mem_req_nxt = 1'b0;
            fault_nxt   = 1'b1;
         end

         default: begin
            mem_req_nxt = 1'b0;
            fault_nxt   = 1'b1;
            state_nxt   = FAULT;
         end
      endcase
   end

endmodule

// File: tb/tb_riscv_mem_sequencer.sv
// Scoreboard bench for riscv_mem_sequencer: directed instruction sequence against a
// programmable-latency memory responder.
module tb_riscv_mem_sequencer;

   localparam int unsigned XLEN = 64;

   logic            clk;
   logic            reset;
   logic [XLEN-1:0] core_pc;
   logic [31:0]     core_instr;
   logic            core_memread;
   logic            core_memwrite;
   logic [XLEN-1:0] core_addr;
   logic [XLEN-1:0] core_wdata;
   logic [XLEN-1:0] core_rdata;
   logic            core_step;
   logic            mem_req;
   logic            mem_we;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic [XLEN-1:0] mem_rdata;
   logic            mem_ack;
   logic            halt_req;
   logic            halted;
   logic            fault;
   logic [XLEN-1:0] instret;

   riscv_mem_sequencer #(.XLEN(XLEN), .TIMEOUT(4), .NOP(32'h0000_0013)) dut (
      .clk(clk), .reset(reset),
      .core_pc(core_pc), .core_instr(core_instr),
      .core_memread(core_memread), .core_memwrite(core_memwrite),
      .core_addr(core_addr), .core_wdata(core_wdata),
      .core_rdata(core_rdata), .core_step(core_step),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .halt_req(halt_req), .halted(halted), .fault(fault), .instret(instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        is_step;
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
      int          len;
      logic [63:0] instret;
      logic [63:0] rdata;
      logic [31:0] instr;
   } exp_t;

   exp_t        exp_q[$];
   int          delay_q[$];
   logic [63:0] mem    [logic [63:0]];
   logic [63:0] wr_mem [logic [63:0]];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t req_e(input logic we, input logic [63:0] a,
                                  input logic [63:0] wd, input int len);
      exp_t e;
      e.is_step = 1'b0; e.we = we; e.addr = a; e.wdata = wd; e.len = len;
      e.instret = '0; e.rdata = '0; e.instr = '0;
      return e;
   endfunction

   function automatic exp_t step_e(input logic [63:0] n, input logic [63:0] rd,
                                   input logic [31:0] ins);
      exp_t e;
      e.is_step = 1'b1; e.we = 1'b0; e.addr = '0; e.wdata = '0; e.len = 0;
      e.instret = n; e.rdata = rd; e.instr = ins;
      return e;
   endfunction

   // Memory responder: each request pops an ack delay (-1 = never ack)
   int   resp_cnt   = 0;
   int   resp_delay = 0;
   logic resp_prev  = 1'b0;
   always @(negedge clk) begin
      if (!mem_req) begin
         mem_ack   = 1'b0;
         resp_prev = 1'b0;
      end else begin
         if (!resp_prev) begin
            resp_delay = 0;
            if (delay_q.size() > 0) resp_delay = delay_q.pop_front();
            resp_cnt = 0;
         end
         resp_prev = 1'b1;
         if (resp_delay >= 0 && resp_cnt == resp_delay) begin
            mem_ack = 1'b1;
            if (mem_we) wr_mem[mem_addr] = mem_wdata;
            else        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 64'h0;
         end else begin
            mem_ack = 1'b0;
         end
         resp_cnt++;
      end
   end

   // Monitor: pops expectations on each new request and each commit pulse
   logic mon_prev = 1'b0;
   int   req_len  = 0;
   exp_t cur;
   always @(negedge clk) begin
      if (reset) begin
         mon_prev = 1'b0;
      end else begin
         if (mem_req && !mon_prev) begin
            if (exp_q.size() == 0 || exp_q[0].is_step) begin
               chk("unexpected_req", {63'h0, mem_req}, 64'h0);
               cur = req_e(mem_we, mem_addr, mem_wdata, 0);
            end else begin
               cur = exp_q.pop_front();
               chk("req_we", {63'h0, mem_we}, {63'h0, cur.we});
               chk("req_addr", mem_addr, cur.addr);
               chk("req_wdata", mem_wdata, cur.wdata);
            end
            req_len = 1;
         end else if (mem_req) begin
            req_len++;
            chk("req_hold_we", {63'h0, mem_we}, {63'h0, cur.we});
            chk("req_hold_addr", mem_addr, cur.addr);
            chk("req_hold_wdata", mem_wdata, cur.wdata);
         end
         if (!mem_req && mon_prev && cur.len != 0)
            chk("req_len", 64'(req_len), 64'(cur.len));
         if (core_step) begin
            if (exp_q.size() == 0 || !exp_q[0].is_step) begin
               chk("unexpected_step", {63'h0, core_step}, 64'h0);
            end else begin
               cur = exp_q.pop_front();
               chk("step_instret", instret, cur.instret);
               chk("step_rdata", core_rdata, cur.rdata);
               chk("step_instr", {32'h0, core_instr}, {32'h0, cur.instr});
            end
         end
         mon_prev = mem_req;
      end
   end

   task automatic wait_step(input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!core_step && n < budget);
      chk("step_seen", {63'h0, core_step}, 64'h1);
   endtask

   task automatic wait_req(input int budget);
      int n = 0;
      while (!mem_req && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("req_seen", {63'h0, mem_req}, 64'h1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_instr"}, {32'h0, core_instr}, 64'h13);
      chk({tag, "_rdata"}, core_rdata, 64'h0);
      chk({tag, "_step"}, {63'h0, core_step}, 64'h0);
      chk({tag, "_req"}, {63'h0, mem_req}, 64'h0);
      chk({tag, "_we"}, {63'h0, mem_we}, 64'h0);
      chk({tag, "_addr"}, mem_addr, 64'h0);
      chk({tag, "_wdata"}, mem_wdata, 64'h0);
      chk({tag, "_halted"}, {63'h0, halted}, 64'h0);
      chk({tag, "_fault"}, {63'h0, fault}, 64'h0);
      chk({tag, "_instret"}, instret, 64'h0);
   endtask

   task automatic set_core(input logic [63:0] pc, input logic rd, input logic wr,
                           input logic [63:0] a, input logic [63:0] wd);
      core_pc = pc; core_memread = rd; core_memwrite = wr; core_addr = a; core_wdata = wd;
   endtask

   initial begin
      int n;
      reset = 1'b1; halt_req = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
      set_core(64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
      mem[64'h00]  = 64'h0000_0000_0000_0013;
      mem[64'h04]  = 64'h0000_0000_0000_3083;
      mem[64'h08]  = 64'h0000_0000_0011_3023;
      mem[64'h0C]  = 64'h0000_0000_0000_0013;
      mem[64'h10]  = 64'h0000_0000_0000_0013;
      mem[64'h14]  = 64'h0000_0000_0000_0013;
      mem[64'h18]  = 64'h0000_0000_0000_0013;
      mem[64'h100] = 64'h0000_0000_DEAD_BEEF;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("rst0");

      // NOP at pc 0, zero-wait memory
      exp_q.push_back(req_e(1'b0, 64'h0, 64'h0, 1));
      exp_q.push_back(step_e(64'd1, 64'h0, 32'h0000_0013));
      delay_q.push_back(0);
      reset = 1'b0;
      wait_step(20, n);
      chk("nop_latency", 64'(n), 64'd3);

      // Load with 2 wait cycles
      set_core(64'h4, 1'b1, 1'b0, 64'h100, 64'h0);
      exp_q.push_back(req_e(1'b0, 64'h4, 64'h0, 1));
      exp_q.push_back(req_e(1'b0, 64'h100, 64'h0, 3));
      exp_q.push_back(step_e(64'd2, 64'hDEAD_BEEF, 32'h0000_3083));
      delay_q.push_back(0); delay_q.push_back(2);
      wait_step(30, n);
      chk("load_latency", 64'(n), 64'd7);

      // Store with 1 wait cycle; core_rdata keeps the loaded value
      set_core(64'h8, 1'b0, 1'b1, 64'h40, 64'h1234);
      exp_q.push_back(req_e(1'b0, 64'h8, 64'h0, 1));
      exp_q.push_back(req_e(1'b1, 64'h40, 64'h1234, 2));
      exp_q.push_back(step_e(64'd3, 64'hDEAD_BEEF, 32'h0011_3023));
      delay_q.push_back(0); delay_q.push_back(1);
      wait_step(30, n);
      chk("store_latency", 64'(n), 64'd6);
      chk("store_mem", wr_mem.exists(64'h40) ? wr_mem[64'h40] : 64'hX, 64'h1234);

      // Halt requested during fetch wait
      set_core(64'hC, 1'b0, 1'b0, 64'h0, 64'h0);
      exp_q.push_back(req_e(1'b0, 64'hC, 64'h1234, 2));
      exp_q.push_back(step_e(64'd4, 64'hDEAD_BEEF, 32'h0000_0013));
      delay_q.push_back(1);
      wait_req(10);
      halt_req = 1'b1;
      wait_step(20, n);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("halt_halted", {63'h0, halted}, 64'h1);
         chk("halt_noreq", {63'h0, mem_req}, 64'h0);
      end
      set_core(64'h10, 1'b0, 1'b0, 64'h0, 64'h0);
      exp_q.push_back(req_e(1'b0, 64'h10, 64'h1234, 1));
      exp_q.push_back(step_e(64'd5, 64'hDEAD_BEEF, 32'h0000_0013));
      delay_q.push_back(0);
      halt_req = 1'b0;
      @(negedge clk);
      chk("resume_halted", {63'h0, halted}, 64'h0);
      chk("resume_issue", {63'h0, mem_req}, 64'h0);
      @(negedge clk);
      chk("resume_req", {63'h0, mem_req}, 64'h1);
      wait_step(20, n);

      // Ack on the last allowed wait cycle is accepted
      set_core(64'h14, 1'b0, 1'b0, 64'h0, 64'h0);
      exp_q.push_back(req_e(1'b0, 64'h14, 64'h1234, 4));
      exp_q.push_back(step_e(64'd6, 64'hDEAD_BEEF, 32'h0000_0013));
      delay_q.push_back(3);
      wait_step(30, n);
      chk("late_ack_latency", 64'(n), 64'd7);
      chk("late_ack_nofault", {63'h0, fault}, 64'h0);

      // No ack: timeout fault after 4 wait cycles
      set_core(64'h18, 1'b0, 1'b0, 64'h0, 64'h0);
      exp_q.push_back(req_e(1'b0, 64'h18, 64'h1234, 4));
      delay_q.push_back(-1);
      wait_req(10);
      n = 0;
      while (!fault && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("timeout_cycles", 64'(n), 64'd4);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("fault_sticky", {63'h0, fault}, 64'h1);
         chk("fault_noreq", {63'h0, mem_req}, 64'h0);
         chk("fault_nostep", {63'h0, core_step}, 64'h0);
         chk("fault_instret", instret, 64'd6);
      end

      // Misaligned pc faults without any request
      reset = 1'b1;
      set_core(64'h6, 1'b0, 1'b0, 64'h0, 64'h0);
      repeat (2) @(negedge clk);
      chk_reset_vals("rst1");
      reset = 1'b0;
      @(negedge clk);
      chk("misalign_fault", {63'h0, fault}, 64'h1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("misalign_noreq", {63'h0, mem_req}, 64'h0);
      end

      // memread and memwrite together fault in EXEC
      reset = 1'b1;
      set_core(64'h0, 1'b1, 1'b1, 64'h100, 64'h55);
      @(negedge clk);
      exp_q.push_back(req_e(1'b0, 64'h0, 64'h0, 1));
      delay_q.push_back(0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rdwr_fault", {63'h0, fault}, 64'h1);
      chk("rdwr_noreq", {63'h0, mem_req}, 64'h0);

      // Reset in the middle of a data wait
      reset = 1'b1;
      mem[64'h00] = 64'h0000_0000_0000_3083;
      set_core(64'h0, 1'b1, 1'b0, 64'h100, 64'h0);
      @(negedge clk);
      exp_q.push_back(req_e(1'b0, 64'h0, 64'h0, 1));
      exp_q.push_back(req_e(1'b0, 64'h100, 64'h0, 0));
      delay_q.push_back(0); delay_q.push_back(-1);
      reset = 1'b0;
      n = 0;
      while (!(mem_req && mem_addr == 64'h100) && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("midwait_req", {63'h0, mem_req}, 64'h1);
      chk("midwait_instr", {32'h0, core_instr}, 64'h3083);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk_reset_vals("rst2");
      reset = 1'b0;
      set_core(64'h6, 1'b0, 1'b0, 64'h0, 64'h0);
      repeat (2) @(negedge clk);

      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
